// File: rtl/des_f_if.sv
// Handshake bundle between the Feistel/key-schedule side and the serial DES f-function.
// The master drives operands and out_ready; the slave (des_f_serial) returns results.
interface des_f_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] r_in;
  logic [47:0] k_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f_out;
  logic        busy;

  modport master (
    output in_valid, r_in, k_in, out_ready,
    input  in_ready, out_valid, f_out, busy
  );

  modport slave (
    input  in_valid, r_in, k_in, out_ready,
    output in_ready, out_valid, f_out, busy
  );
endinterface

// File: rtl/des_f_serial.sv
// Serial DES round function f(R,K): E + key mix, one S-box per cycle, then P.
// Define DES_F_SHUFFLE_EN to rotate the S-box evaluation order from an 8-bit LFSR.
module des_f_serial #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic   clk,
  input logic   rst,
  des_f_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SBOX, DONE} state_t;

  // Each entry is one S-box, 64 nibbles in row-major order (row*16 + column).
  localparam logic [255:0] SBOX_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [47:0] expand(input logic [31:0] r);
    return {r[0], r[31:27], r[28:23], r[24:19], r[20:15],
            r[16:11], r[12:7], r[8:3], r[4:0], r[31]};
  endfunction

  function automatic logic [31:0] permute(input logic [31:0] s);
    return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
            s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
            s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
            s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
  endfunction

  function automatic logic [3:0] sbox(input logic [2:0] box, input logic [5:0] c);
    logic [5:0] idx;
    idx = {c[5], c[0], c[4:1]};
    return SBOX_TAB[box][255 - 4*int'(idx) -: 4];
  endfunction

  state_t      state;
  logic [2:0]  cnt;
  logic [47:0] mix;
  logic [31:0] acc;
  logic [2:0]  j;
  logic [5:0]  chunk;
  logic [3:0]  sout;
  logic [31:0] acc_next;

`ifdef DES_F_SHUFFLE_EN
  logic [7:0] lfsr;
  logic [2:0] start_off;

  // The start offset is the LFSR value seen at acceptance, before it steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= LFSR_SEED;
      start_off <= 3'd0;
    end else if (state == IDLE && bus.in_valid) begin
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      start_off <= lfsr[2:0];
    end
  end

  assign j = start_off + cnt;
`else
  assign j = cnt;
`endif

  always_comb begin
    chunk    = mix[47 - 6*int'(j) -: 6];
    sout     = sbox(j, chunk);
    acc_next = acc;
    acc_next[31 - 4*int'(j) -: 4] = sout;
  end

  // f_out is loaded from acc_next so the eighth nibble is included without an extra cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      mix           <= 48'd0;
      acc           <= 32'd0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.f_out     <= 32'd0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mix          <= expand(bus.r_in) ^ bus.k_in;
            acc          <= 32'd0;
            cnt          <= 3'd0;
            state        <= SBOX;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        SBOX: begin
          acc <= acc_next;
          if (cnt == 3'd7) begin
            cnt           <= 3'd0;
            state         <= DONE;
            bus.f_out     <= permute(acc_next);
            bus.out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  seed_nonzero: assert property (@(posedge clk) LFSR_SEED != 8'h00);

endmodule

// File: tb/tb_des_f_serial.sv
// Self-checking bench for des_f_serial: hand-computed vector table, handshake corner cases,
// back-to-back random operands against an independent table-driven DES f model.
module tb_des_f_serial;

  logic clk = 1'b0;
  logic rst = 1'b0;
  des_f_if bus_if ();

  des_f_serial #(.LFSR_SEED(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int E_TAB [48] = '{
    32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32, 1};

  localparam int P_TAB [32] = '{
    16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
     2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};

  localparam int S_TAB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [31:0] golden_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    int row, col, val;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TAB[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      row = 2*int'(x[47-6*b]) + int'(x[42-6*b]);
      col = 8*int'(x[46-6*b]) + 4*int'(x[45-6*b]) + 2*int'(x[44-6*b]) + int'(x[43-6*b]);
      val = S_TAB[b][row*16 + col];
      for (int i = 0; i < 4; i++) s[31-4*b-i] = val[3-i];
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TAB[i]];
    return p;
  endfunction

  typedef struct {
    logic [31:0] r;
    logic [47:0] k;
    logic [31:0] exp_f;
  } vec_t;

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Accept one operand pair, then wait (bounded) for out_valid; lat counts edges after accept.
  task automatic applyStimulus(input logic [31:0] r, input logic [47:0] k, output int lat);
    bus_if.r_in     = r;
    bus_if.k_in     = k;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    bus_if.r_in     = $urandom;
    bus_if.k_in     = {$urandom, $urandom} >> 16;
    lat = 0;
    while (!bus_if.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("reset in_ready",  48'(bus_if.in_ready),  48'd1);
    checkOutput("reset out_valid", 48'(bus_if.out_valid), 48'd0);
    checkOutput("reset busy",      48'(bus_if.busy),      48'd0);
    checkOutput("reset f_out",     48'(bus_if.f_out),     48'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [4];
    int lat;
    int accepts, last_acc, cyc;
    logic pending;
    logic [31:0] expq [$];
    logic [63:0] rnd;

    vecs[0] = '{32'hF0AAF0AA, 48'h1B02EFFC7072, 32'h234AA9BB};
    vecs[1] = '{32'h00000000, 48'h000000000000, 32'hD8D8DBBC};
    vecs[2] = '{32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 32'hD8D8DBBC};
    vecs[3] = '{32'h00000000, 48'hFFFFFFFFFFFF, 32'h38DBF9CB};

    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    bus_if.r_in      = 32'd0;
    bus_if.k_in      = 48'd0;
    @(posedge clk); #1;
    doReset();

`ifdef DES_F_SHUFFLE_EN
    begin
      logic [7:0] mdl_lfsr;
      mdl_lfsr = 8'hA5;
      for (int n = 0; n < 10; n++) begin
        applyStimulus(32'hF0AAF0AA, 48'h1B02EFFC7072, lat);
        checkOutput("shuffle start", 48'(dut.start_off), 48'(mdl_lfsr[2:0]));
        checkOutput("shuffle f_out", 48'(bus_if.f_out), 48'h234AA9BB);
        mdl_lfsr = {mdl_lfsr[6:0], mdl_lfsr[7] ^ mdl_lfsr[5] ^ mdl_lfsr[4] ^ mdl_lfsr[3]};
        @(posedge clk); #1;
      end
    end
`endif

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].r, vecs[i].k, lat);
      checkOutput("latency",        48'(lat),              48'd8);
      checkOutput("f_out",          48'(bus_if.f_out),     48'(vecs[i].exp_f));
      checkOutput("busy in DONE",   48'(bus_if.busy),      48'd1);
      checkOutput("in_ready DONE",  48'(bus_if.in_ready),  48'd0);
      @(posedge clk); #1;
      checkOutput("out_valid 1cyc", 48'(bus_if.out_valid), 48'd0);
      checkOutput("in_ready IDLE",  48'(bus_if.in_ready),  48'd1);
      checkOutput("f_out kept",     48'(bus_if.f_out),     48'(vecs[i].exp_f));
    end

    // Backpressure: result must hold and a second in_valid must be ignored.
    bus_if.out_ready = 1'b0;
    applyStimulus(32'hF0AAF0AA, 48'h1B02EFFC7072, lat);
    checkOutput("bp latency", 48'(lat), 48'd8);
    bus_if.r_in     = 32'd0;
    bus_if.k_in     = 48'd0;
    bus_if.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("bp out_valid", 48'(bus_if.out_valid), 48'd1);
      checkOutput("bp in_ready",  48'(bus_if.in_ready),  48'd0);
      checkOutput("bp f_out",     48'(bus_if.f_out),     48'h234AA9BB);
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp release in_ready",  48'(bus_if.in_ready),  48'd1);
    checkOutput("bp release out_valid", 48'(bus_if.out_valid), 48'd0);
    checkOutput("bp release busy",      48'(bus_if.busy),      48'd0);

    // Abort mid-operation at cnt == 4, then a clean run.
    bus_if.r_in     = 32'hF0AAF0AA;
    bus_if.k_in     = 48'h1B02EFFC7072;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("busy before abort", 48'(bus_if.busy), 48'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort in_ready",  48'(bus_if.in_ready),  48'd1);
    checkOutput("abort out_valid", 48'(bus_if.out_valid), 48'd0);
    checkOutput("abort busy",      48'(bus_if.busy),      48'd0);
    checkOutput("abort f_out",     48'(bus_if.f_out),     48'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(32'h00000000, 48'hFFFFFFFFFFFF, lat);
    checkOutput("post-abort latency", 48'(lat),          48'd8);
    checkOutput("post-abort f_out",   48'(bus_if.f_out), 48'h38DBF9CB);
    @(posedge clk); #1;

    // Back-to-back random operands with in_valid held high.
    accepts  = 0;
    last_acc = -1;
    cyc      = 0;
    rnd = {$urandom, $urandom};
    bus_if.r_in     = rnd[31:0];
    bus_if.k_in     = rnd[63:16];
    bus_if.in_valid = 1'b1;
    while ((accepts < 100 || expq.size() != 0) && cyc < 1500) begin
      pending = bus_if.in_valid && bus_if.in_ready;
      if (pending) begin
        expq.push_back(golden_f(bus_if.r_in, bus_if.k_in));
        if (last_acc >= 0) checkOutput("accept spacing", 48'(cyc - last_acc), 48'd10);
        last_acc = cyc;
        accepts++;
      end
      @(posedge clk); #1;
      cyc++;
      if (pending) begin
        if (accepts >= 100) begin
          bus_if.in_valid = 1'b0;
        end else begin
          rnd = {$urandom, $urandom};
          bus_if.r_in = rnd[31:0];
          bus_if.k_in = rnd[63:16];
        end
      end
      if (bus_if.out_valid) begin
        if (expq.size() == 0) checkOutput("unexpected out_valid", 48'd1, 48'd0);
        else checkOutput("b2b f_out", 48'(bus_if.f_out), 48'(expq.pop_front()));
      end
    end
    checkOutput("b2b accepts",   48'(accepts),     48'd100);
    checkOutput("b2b drained",   48'(expq.size()), 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
